// File: rtl/conv_stream_layer.sv
// Streaming KxK convolution over a raster pixel stream, CH output channels,
// fixed-point multiply-accumulate with saturation, optional ReLU, valid/ready output.
module conv_stream_layer #(
  parameter int BITWIDTH = 16,
  parameter int FRAC     = 8,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int K        = 5,
  parameter int CH       = 2,
  parameter int RELU     = 0,
  localparam int CHW     = (CH > 1) ? $clog2(CH) : 1,
  localparam int IDXW    = $clog2(K * K),
  localparam int RW      = $clog2(IMG_H),
  localparam int CW      = $clog2(IMG_W),
  localparam int AW      = 2 * BITWIDTH + $clog2(K * K)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wt_we,
  input  logic [CHW-1:0]      wt_ch,
  input  logic [IDXW-1:0]     wt_idx,
  input  logic [BITWIDTH-1:0] wt_data,
  input  logic                start,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [BITWIDTH-1:0] pix_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data [CH-1:0],
  output logic [RW-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                busy,
  output logic                done,
  output logic                state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [AW-1:0] SMAX = AW'((64'sd1 <<< (BITWIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  state_t state, state_nx;

  logic [RW-1:0] in_row;
  logic [CW-1:0] in_col;
  logic          in_done;

  logic signed [BITWIDTH-1:0] wt      [CH][K*K];
  logic signed [BITWIDTH-1:0] lb      [K-1][IMG_W];
  logic signed [BITWIDTH-1:0] win     [K][K];
  logic signed [BITWIDTH-1:0] win_nx  [K][K];
  logic signed [BITWIDTH-1:0] col_new [K];
  logic signed [AW-1:0]       acc     [CH];
  logic signed [AW-1:0]       sh      [CH];
  logic signed [BITWIDTH-1:0] res     [CH];

  logic pix_acc, win_ok, out_fire, last_out, wt_wr;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a producer holding valid
  // keeps its payload stable until the transfer completes.
  assign pix_ready = (state == RUN) && (!out_valid || out_ready) && !in_done;
  assign pix_acc   = pix_valid && pix_ready;
  assign win_ok    = (in_row >= RW'(K - 1)) && (in_col >= CW'(K - 1));
  assign out_fire  = out_valid && out_ready;
  assign last_out  = (out_row == RW'(IMG_H - K)) && (out_col == CW'(IMG_W - K));
  assign done      = out_fire && last_out;
  assign busy      = (state == RUN);
  assign state_dbg = state;
  assign wt_wr     = (state == IDLE) && wt_we && (int'(wt_ch) < CH) && (int'(wt_idx) < K * K);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Row 0 of the window is the oldest buffered row; row K-1 is the live pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col_new[r] = lb[r][in_col];
    col_new[K-1] = pix_data;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        if (c < K - 1) win_nx[r][c] = win[r][c+1];
        else           win_nx[r][c] = col_new[r];
  end

  always_comb begin
    for (int ch = 0; ch < CH; ch++) begin
      acc[ch] = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          acc[ch] = acc[ch] + AW'(win_nx[r][c]) * AW'(wt[ch][r*K+c]);
      sh[ch] = acc[ch] >>> FRAC;
      if (sh[ch] > SMAX)      res[ch] = BITWIDTH'(SMAX);
      else if (sh[ch] < SMIN) res[ch] = BITWIDTH'(SMIN);
      else                    res[ch] = sh[ch][BITWIDTH-1:0];
      if (RELU != 0 && res[ch][BITWIDTH-1]) res[ch] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_row    <= '0;
      in_col    <= '0;
      in_done   <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      for (int ch = 0; ch < CH; ch++) begin
        out_data[ch] <= '0;
        for (int i = 0; i < K * K; i++) wt[ch][i] <= '0;
      end
    end else begin
      if (state == IDLE && start) begin
        in_row  <= '0;
        in_col  <= '0;
        in_done <= 1'b0;
      end else if (pix_acc) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          if (in_row == RW'(IMG_H - 1)) in_done <= 1'b1;
          else                          in_row  <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end

      if (wt_wr) wt[wt_ch][wt_idx] <= wt_data;

      if (pix_acc && win_ok) begin
        out_valid <= 1'b1;
        out_row   <= in_row - RW'(K - 1);
        out_col   <= in_col - CW'(K - 1);
        for (int ch = 0; ch < CH; ch++) out_data[ch] <= res[ch];
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffers and window carry no reset: only fully refilled windows are ever emitted.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      for (int r = 0; r < K - 1; r++) lb[r][in_col] <= col_new[r+1];
      win <= win_nx;
    end
  end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Bench for conv_stream_layer: table of uniform frames, identity/ramp frame,
// randomized frames with backpressure against a direct-convolution model.
module tb_conv_stream_layer;
  localparam int BW   = 16;
  localparam int FRAC = 8;
  localparam int W    = 32;
  localparam int H    = 32;
  localparam int K    = 5;
  localparam int CH   = 2;
  localparam int NOUT = (W - K + 1) * (H - K + 1);
  localparam int EW   = 10 + 4 * BW;

  logic clk = 1'b0;
  logic rst;
  logic wt_we;
  logic [0:0] wt_ch;
  logic [4:0] wt_idx;
  logic [BW-1:0] wt_data;
  logic start, pix_valid, out_ready;
  logic [BW-1:0] pix_data;
  logic pix_ready, out_valid, busy, done, state_dbg;
  logic [BW-1:0] out_data [CH-1:0];
  logic [4:0] out_row, out_col;
  logic r_pix_ready, r_out_valid, r_busy, r_done, r_state_dbg;
  logic [BW-1:0] r_out_data [CH-1:0];
  logic [4:0] r_out_row, r_out_col;

  always #5 clk = ~clk;

  conv_stream_layer dut (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_ch(wt_ch), .wt_idx(wt_idx), .wt_data(wt_data),
    .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  conv_stream_layer #(.RELU(1)) dut_r (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_ch(wt_ch), .wt_idx(wt_idx), .wt_data(wt_data),
    .start(start), .pix_valid(pix_valid), .pix_ready(r_pix_ready), .pix_data(pix_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_row(r_out_row), .out_col(r_out_col), .busy(r_busy), .done(r_done), .state_dbg(r_state_dbg)
  );

  int checks = 0;
  int failures = 0;

  logic signed [BW-1:0] img [H][W];
  logic signed [BW-1:0] mw  [CH][K*K];
  logic [EW-1:0] exp_q [$];

  typedef struct {
    string       name;
    logic [15:0] w;
    logic [15:0] p;
    logic [15:0] e_n;
    logic [15:0] e_r;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Direct convolution of the window whose top-left pixel is (i,j).
  function automatic logic [BW-1:0] ref_px(input int i, input int j, input int ch, input bit relu);
    longint acc = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc += longint'(img[i+r][j+c]) * longint'(mw[ch][r*K+c]);
    acc = acc >>> FRAC;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return BW'(acc);
  endfunction

  task automatic wr_w(input int ch, input int idx, input logic [15:0] v, input bit upd);
    @(negedge clk);
    wt_we = 1'b1; wt_ch = 1'(ch); wt_idx = 5'(idx); wt_data = v;
    @(negedge clk);
    wt_we = 1'b0;
    if (upd && idx < K * K) mw[ch][idx] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_busy"}, {busy, state_dbg}, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_pos"}, {out_row, out_col}, 0);
    check({tag, "_out_data"}, {out_data[1], out_data[0]}, 0);
  endtask

  task automatic run_frame(input int rdy_pct, input int rst_at, input bit run_wr,
                           input bit ident, input bit uni, input logic [15:0] u_n,
                           input logic [15:0] u_r);
    int idx = 0, nout = 0, ndone = 0, cyc = 0;
    bit fin = 0, held = 0;
    logic [41:0] hv;
    logic [EW-1:0] e;
    logic [15:0] f;
    exp_q.delete();
    for (int i = 0; i <= H - K; i++)
      for (int j = 0; j <= W - K; j++)
        exp_q.push_back({5'(i), 5'(j), ref_px(i, j, 1, 1), ref_px(i, j, 0, 1),
                         ref_px(i, j, 1, 0), ref_px(i, j, 0, 0)});
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", {busy, state_dbg}, 2'b11);
    check("pix_ready_after_start", pix_ready, 1);
    while (!fin && cyc < 8000) begin
      pix_valid = 1'b1;
      pix_data  = (idx < W * H) ? img[idx / W][idx % W] : '0;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      wt_we     = run_wr && (cyc == 50);
      wt_ch = 1'b0; wt_idx = 5'd12; wt_data = 16'h7FFF;
      #1;
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_row, out_col, out_data[1], out_data[0]}, hv);
      end
      held = out_valid && !out_ready;
      hv = {out_row, out_col, out_data[1], out_data[0]};
      if (done) ndone++;
      if (out_valid && out_ready) begin
        check("relu_lockstep", {r_out_valid, r_out_row, r_out_col}, {1'b1, out_row, out_col});
        if (exp_q.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_main", {out_row, out_col, out_data[1], out_data[0]}, {e[73:64], e[31:0]});
          check("out_relu", {r_out_data[1], r_out_data[0]}, e[63:32]);
        end
        if (ident) begin
          f = 16'(((int'(out_row) + 2) * 32 + int'(out_col) + 2) << 8);
          check("ident_ch0", out_data[0], f);
          check("ident_ch1", out_data[1], 0);
        end
        if (uni)
          check("uniform", {out_data[1], out_data[0], r_out_data[1], r_out_data[0]},
                {u_n, u_n, u_r, u_r});
        nout++;
        if (done) fin = 1;
      end
      if (pix_valid && pix_ready) idx++;
      if (rst_at > 0 && idx == rst_at) begin
        @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b0; wt_we = 1'b0;
        for (int ch = 0; ch < CH; ch++)
          for (int i = 0; i < K * K; i++) mw[ch][i] = '0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    wt_we = 1'b0;
    pix_valid = 1'b0;
    #1;
    check("frame_finished", fin, 1);
    check("out_count", nout, NOUT);
    check("done_count", ndone, 1);
    check("queue_empty", exp_q.size(), 0);
    check("idle_after_done", {busy, state_dbg, pix_ready, out_valid}, 0);
  endtask

  initial begin
    vecs[0] = '{"ones",     16'h0100, 16'h0100, 16'h1900, 16'h1900};
    vecs[1] = '{"negative", 16'hFF00, 16'h0100, 16'hE700, 16'h0000};
    vecs[2] = '{"sat_pos",  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{"sat_neg",  16'h8000, 16'h7FFF, 16'h8000, 16'h0000};

    rst = 1'b1; wt_we = 1'b0; wt_ch = '0; wt_idx = '0; wt_data = '0;
    start = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0;
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < K * K; i++) mw[ch][i] = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("after_reset");

    // Identity kernel on a ramp image.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 16'((r * 32 + c) << 8);
    wr_w(0, 12, 16'h0100, 1);
    run_frame(100, 0, 0, 1, 0, 16'h0, 16'h0);

    // Uniform image/weight vectors with constant expected outputs.
    for (int v = 0; v < 4; v++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[r][c] = vecs[v].p;
      for (int ch = 0; ch < CH; ch++)
        for (int i = 0; i < K * K; i++) wr_w(ch, i, vecs[v].w, 1);
      run_frame(100, 0, 0, 0, 1, vecs[v].e_n, vecs[v].e_r);
    end

    // Random weights and image; same frame with and without backpressure.
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < K * K; i++) wr_w(ch, i, 16'(int'($urandom_range(0, 128)) - 64), 1);
    wr_w(1, 27, 16'h7FFF, 1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 16'($urandom);
    run_frame(100, 0, 0, 0, 0, 16'h0, 16'h0);
    run_frame(30, 0, 0, 0, 0, 16'h0, 16'h0);

    // Weight write while running is dropped; the same write in IDLE takes effect.
    run_frame(100, 0, 1, 0, 0, 16'h0, 16'h0);
    wr_w(0, 12, 16'h7FFF, 1);
    run_frame(100, 0, 0, 0, 0, 16'h0, 16'h0);

    // Reset mid-frame, then only channel 0 reloaded: channel 1 must read as cleared.
    run_frame(100, 400, 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < K * K; i++) wr_w(0, i, 16'(int'($urandom_range(0, 512)) - 256), 1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 16'(int'($urandom_range(0, 4096)) - 2048);
    run_frame(70, 0, 0, 0, 0, 16'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
